vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port, pipelined 32 KB video RAM between three requesters: the video fetch engine, CPU writes/reads to screen pages, and the snapshot/tape loader DMA.
- Sits between the video controller's vram_addr/vram_dout pair and the SDRAM/BRAM screen copy.
- Video fetch must never be delayed. CPU and loader share the remaining slots with fixed priority plus starvation relief.

Parameters:
- RD_LAT, 1, RAM read latency in clk_sys cycles (1..3).
- STARVE_MAX, 15, consecutive lost-arbitration cycles after which the loader outranks the CPU for one grant.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- vid_req  in  1  video read request, single-cycle pulse, at most one per ce_7mn period
- vid_addr  in  15  video read address
- vid_dout  out  8  video read data
- vid_valid  out  1  vid_dout valid pulse
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  CPU write enable
- cpu_addr  in  15  CPU address
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data
- cpu_ack  out  1  one-cycle grant pulse; for reads, data valid with cpu_rvalid
- cpu_rvalid  out  1  CPU read data valid pulse
- ldr_req  in  1  loader request, level, held until ldr_ack
- ldr_we  in  1  loader write enable
- ldr_addr  in  15  loader address
- ldr_din  in  8  loader write data
- ldr_dout  out  8  loader read data
- ldr_ack  out  1  loader grant pulse
- ldr_rvalid  out  1  loader read data valid pulse
- ram_addr  out  15  RAM address
- ram_din  out  8  RAM write data
- ram_we  out  1  RAM write strobe
- ram_dout  in  8  RAM read data, RD_LAT cycles after issue

Behaviour:
- One access is issued per clk_sys cycle. Grant is combinational on the request inputs; ram_* and ack are registered, so an access issues one cycle after it is requested.
- Priority each cycle: video, then loader if starved, then CPU, then loader.
  - vid_req always wins.
  - A request held by CPU or loader that loses simply retries next cycle; no request is dropped.
- Ack and hold rules:
  - cpu_ack/ldr_ack pulse in the issue cycle.
  - The requester must deassert, or present a new request, on the cycle after ack.
  - A req still high after ack is treated as a new request.
- Tag pipeline, depth RD_LAT+1:
  - Each issued access carries an owner tag (NONE/VID/CPU/LDR) and a read flag.
  - The returned ram_dout is registered into vid_dout, cpu_dout or ldr_dout.
  - The matching *_valid pulse asserts one cycle after the data arrives.
  - Total read latency = RD_LAT+2 cycles from request. Writes produce no rvalid.
- Starvation counter:
  - 4 bits. Increments each cycle ldr_req is high and the loader is not granted; saturates at 15.
  - Clears on ldr_ack or when ldr_req is low.
  - At count == STARVE_MAX the loader outranks the CPU for exactly one grant.
- Idle cycles: ram_we=0; ram_addr holds its last value.
- Simultaneous vid_req and CPU write to the same address: video issues first and reads old data; the CPU write issues next cycle.
- Reset:
  - All ack/valid/ram_we outputs are 0.
  - Data outputs and ram_addr/ram_din are 0.
  - Tag pipeline is flushed to NONE, so in-flight reads are discarded without valid pulses.
  - Starvation counter is 0.
- Reset mid-transaction: requester must re-request after reset deasserts.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_cpu_stall[15:0] and stat_ldr_stall[15:0]: saturating counts of cycles each requester was pending but not granted.
  - Adds input stat_clr, which zeroes both counters synchronously.
  - Both counters reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package vram_arb_pkg holds:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_VID, OWN_CPU, OWN_LDR}
  - localparam VRAM_AW = 15
  - localparam STARVE_W = 4
- One sub-module: vram_tag_pipe. It is a parameterised RD_LAT+1 shift register of {owner_t, rd} with synchronous flush, and outputs the tag aligned with ram_dout.

Test Plan:
- Basic reads (RD_LAT=1):
  - Preload 0x1800=0x47. vid_req, vid_addr=0x1800 → ram_addr=0x1800 next cycle; vid_dout=0x47 with vid_valid 3 cycles after request.
- Video wins over CPU:
  - vid_req and cpu_req (read 0x0000) in the same cycle → video issues first, cpu_ack one cycle later, cpu_rvalid one cycle after vid_valid.
- Write then read, same address:
  - CPU write 0x4000-page addr 0x0100=0xAA, then CPU read 0x0100 → cpu_dout=0xAA.
  - vid_req to 0x0100 in the write's request cycle returns the old value.
- Starvation relief:
  - cpu_req held continuously, ldr_req high → ldr_ack after exactly 16 cycles (count reaches 15), then the CPU resumes grants.
- Reset with reads in flight:
  - Issue CPU read, assert reset during the RD_LAT window → no cpu_rvalid, all outputs 0, counter 0.
- With VRAM_ARB_STATS_EN:
  - 10 cycles of CPU blocked by vid_req pulses → stat_cpu_stall=10.
  - stat_clr → 0 next cycle.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: access owner tags and address/counter widths.
package vram_arb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU, OWN_LDR} owner_t;

  localparam int VRAM_AW  = 15;
  localparam int STARVE_W = 4;

  typedef struct packed {
    owner_t owner;
    logic   rd;
  } tag_t;

  localparam tag_t TAG_IDLE = '{owner: OWN_NONE, rd: 1'b0};

endpackage

// File: rtl/vram_tag_pipe.sv
// Delays the owner/read tag of each issued access so it lines up with ram_dout.
module vram_tag_pipe
  import vram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk_sys,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  // Stage 0 is aligned with ram_addr; stage RD_LAT is aligned with the returned data.
  tag_t stages [0:RD_LAT];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i <= RD_LAT; i++) stages[i] <= TAG_IDLE;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i <= RD_LAT; i++) stages[i] <= stages[i-1];
    end
  end

  assign tag_out = stages[RD_LAT];

endmodule

// File: rtl/vram_arbiter.sv
// Three-way VRAM arbiter: video always wins, loader outranks CPU only when starved.
// Optional stall statistics are enabled with `define VRAM_ARB_STATS_EN.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               vid_req,
  input  logic [VRAM_AW-1:0] vid_addr,
  output logic [7:0]         vid_dout,
  output logic               vid_valid,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [7:0]         cpu_din,
  output logic [7:0]         cpu_dout,
  output logic               cpu_ack,
  output logic               cpu_rvalid,
  input  logic               ldr_req,
  input  logic               ldr_we,
  input  logic [VRAM_AW-1:0] ldr_addr,
  input  logic [7:0]         ldr_din,
  output logic [7:0]         ldr_dout,
  output logic               ldr_ack,
  output logic               ldr_rvalid,
  output logic [VRAM_AW-1:0] ram_addr,
  output logic [7:0]         ram_din,
  output logic               ram_we,
  input  logic [7:0]         ram_dout
`ifdef VRAM_ARB_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [15:0]        stat_cpu_stall,
  output logic [15:0]        stat_ldr_stall
`endif
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  owner_t               grant;
  logic [STARVE_W-1:0]  starve_cnt;
  logic                 ldr_starved;
  logic [VRAM_AW-1:0]   nxt_addr;
  logic [7:0]           nxt_din;
  logic                 nxt_we;
  logic                 nxt_rd;
  tag_t                 issue_tag;
  tag_t                 ret_tag;

  assign ldr_starved = ldr_req && (starve_cnt == STARVE_LIM);

  always_comb begin
    grant = OWN_NONE;
    if (vid_req)          grant = OWN_VID;
    else if (ldr_starved) grant = OWN_LDR;
    else if (cpu_req)     grant = OWN_CPU;
    else if (ldr_req)     grant = OWN_LDR;
  end

  // Idle cycles keep the previous address/data so the RAM bus only toggles on real accesses.
  always_comb begin
    nxt_addr = ram_addr;
    nxt_din  = ram_din;
    nxt_we   = 1'b0;
    nxt_rd   = 1'b0;
    case (grant)
      OWN_VID: begin
        nxt_addr = vid_addr;
        nxt_rd   = 1'b1;
      end
      OWN_CPU: begin
        nxt_addr = cpu_addr;
        nxt_din  = cpu_din;
        nxt_we   = cpu_we;
        nxt_rd   = !cpu_we;
      end
      OWN_LDR: begin
        nxt_addr = ldr_addr;
        nxt_din  = ldr_din;
        nxt_we   = ldr_we;
        nxt_rd   = !ldr_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      cpu_ack  <= 1'b0;
      ldr_ack  <= 1'b0;
    end else begin
      ram_addr <= nxt_addr;
      ram_din  <= nxt_din;
      ram_we   <= nxt_we;
      cpu_ack  <= (grant == OWN_CPU);
      ldr_ack  <= (grant == OWN_LDR);
    end
  end

  // Cleared on the grant itself so a starved loader wins exactly once, not again in its ack cycle.
  always_ff @(posedge clk_sys) begin
    if (reset || !ldr_req || grant == OWN_LDR) begin
      starve_cnt <= '0;
    end else if (starve_cnt != '1) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign issue_tag.owner = grant;
  assign issue_tag.rd    = nxt_rd;

  vram_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk_sys (clk_sys),
    .reset   (reset),
    .tag_in  (issue_tag),
    .tag_out (ret_tag)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vid_dout   <= '0;
      cpu_dout   <= '0;
      ldr_dout   <= '0;
      vid_valid  <= 1'b0;
      cpu_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
    end else begin
      vid_valid  <= ret_tag.rd && (ret_tag.owner == OWN_VID);
      cpu_rvalid <= ret_tag.rd && (ret_tag.owner == OWN_CPU);
      ldr_rvalid <= ret_tag.rd && (ret_tag.owner == OWN_LDR);
      if (ret_tag.rd && ret_tag.owner == OWN_VID) vid_dout <= ram_dout;
      if (ret_tag.rd && ret_tag.owner == OWN_CPU) cpu_dout <= ram_dout;
      if (ret_tag.rd && ret_tag.owner == OWN_LDR) ldr_dout <= ram_dout;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk_sys) begin
    if (reset || stat_clr) begin
      stat_cpu_stall <= '0;
      stat_ldr_stall <= '0;
    end else begin
      if (cpu_req && grant != OWN_CPU && stat_cpu_stall != 16'hFFFF)
        stat_cpu_stall <= stat_cpu_stall + 16'd1;
      if (ldr_req && grant != OWN_LDR && stat_ldr_stall != 16'hFFFF)
        stat_ldr_stall <= stat_ldr_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural RAM; stats checks run when VRAM_ARB_STATS_EN is defined.
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  localparam int RD_LAT = 1;

  logic               clk_sys = 1'b0;
  logic               reset;
  logic               vid_req, cpu_req, cpu_we, ldr_req, ldr_we;
  logic [VRAM_AW-1:0] vid_addr, cpu_addr, ldr_addr, ram_addr;
  logic [7:0]         cpu_din, ldr_din, ram_din, ram_dout;
  logic [7:0]         vid_dout, cpu_dout, ldr_dout;
  logic               vid_valid, cpu_ack, cpu_rvalid, ldr_ack, ldr_rvalid, ram_we;
`ifdef VRAM_ARB_STATS_EN
  logic               stat_clr;
  logic [15:0]        stat_cpu_stall, stat_ldr_stall;
`endif

  vram_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(15)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_din(ldr_din),
    .ldr_dout(ldr_dout), .ldr_ack(ldr_ack), .ldr_rvalid(ldr_rvalid),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
`ifdef VRAM_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_cpu_stall(stat_cpu_stall), .stat_ldr_stall(stat_ldr_stall)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // Read-first single-port RAM with RD_LAT cycles of read latency.
  logic [7:0] mem [0:32767];
  logic [7:0] rd_pipe [0:RD_LAT-1];
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    rd_pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_dout = rd_pipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk_sys) cyc++;

  typedef struct {
    int         at;
    logic [7:0] data;
  } exp_t;

  exp_t q_vid[$], q_cpu[$], q_ldr[$];
  int   q_cack[$], q_lack[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t e;
  int   ea;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: got pulse, expected none (cycle %0d)", name, cyc);
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [14:0] va,
                               input logic c, input logic cw, input logic [14:0] ca, input logic [7:0] cd,
                               input logic l, input logic lw, input logic [14:0] la, input logic [7:0] ld);
    vid_req = v;  vid_addr = va;
    cpu_req = c;  cpu_we = cw;  cpu_addr = ca;  cpu_din = cd;
    ldr_req = l;  ldr_we = lw;  ldr_addr = la;  ldr_din = ld;
  endtask

  task automatic idle;
    applyStimulus(0, 15'h0, 0, 0, 15'h0, 8'h0, 0, 0, 15'h0, 8'h0);
  endtask

  // Monitor: every output event pops its expectation and checks timing and data.
  always @(negedge clk_sys) begin
    if (vid_valid) begin
      if (q_vid.size() == 0) unexpected("vid_valid");
      else begin
        e = q_vid.pop_front();
        checkOutput("vid_valid cycle", cyc, e.at);
        checkOutput("vid_dout", {24'h0, vid_dout}, {24'h0, e.data});
      end
    end
    if (cpu_rvalid) begin
      if (q_cpu.size() == 0) unexpected("cpu_rvalid");
      else begin
        e = q_cpu.pop_front();
        checkOutput("cpu_rvalid cycle", cyc, e.at);
        checkOutput("cpu_dout", {24'h0, cpu_dout}, {24'h0, e.data});
      end
    end
    if (ldr_rvalid) begin
      if (q_ldr.size() == 0) unexpected("ldr_rvalid");
      else begin
        e = q_ldr.pop_front();
        checkOutput("ldr_rvalid cycle", cyc, e.at);
        checkOutput("ldr_dout", {24'h0, ldr_dout}, {24'h0, e.data});
      end
    end
    if (cpu_ack) begin
      if (q_cack.size() == 0) unexpected("cpu_ack");
      else begin
        ea = q_cack.pop_front();
        checkOutput("cpu_ack cycle", cyc, ea);
      end
    end
    if (ldr_ack) begin
      if (q_lack.size() == 0) unexpected("ldr_ack");
      else begin
        ea = q_lack.pop_front();
        checkOutput("ldr_ack cycle", cyc, ea);
      end
    end
  end

  int c;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    mem[15'h1800] = 8'h47;
    mem[15'h0000] = 8'h5A;
    mem[15'h0100] = 8'h11;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 8'h00;
    reset = 1'b1;
    idle();
`ifdef VRAM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) tick();

    checkOutput("reset ram_we", {31'h0, ram_we}, 0);
    checkOutput("reset ram_addr", {17'h0, ram_addr}, 0);
    checkOutput("reset cpu_ack", {31'h0, cpu_ack}, 0);
    checkOutput("reset vid_valid", {31'h0, vid_valid}, 0);
    checkOutput("reset starve_cnt", {28'h0, dut.starve_cnt}, 0);
    reset = 1'b0;
    tick();

    $display("[TB] basic video read");
    c = cyc;
    applyStimulus(1, 15'h1800, 0, 0, 15'h0, 8'h0, 0, 0, 15'h0, 8'h0);
    q_vid.push_back('{c + 3, 8'h47});
    tick(); idle();
    checkOutput("vid issue ram_addr", {17'h0, ram_addr}, 32'h1800);
    checkOutput("vid issue ram_we", {31'h0, ram_we}, 0);
    repeat (4) tick();

    $display("[TB] video beats cpu");
    c = cyc;
    applyStimulus(1, 15'h1800, 1, 0, 15'h0000, 8'h0, 0, 0, 15'h0, 8'h0);
    q_vid.push_back('{c + 3, 8'h47});
    q_cack.push_back(c + 2);
    q_cpu.push_back('{c + 4, 8'h5A});
    tick();
    applyStimulus(0, 15'h0, 1, 0, 15'h0000, 8'h0, 0, 0, 15'h0, 8'h0);
    checkOutput("vid first ram_addr", {17'h0, ram_addr}, 32'h1800);
    tick(); idle();
    checkOutput("cpu second ram_addr", {17'h0, ram_addr}, 32'h0000);
    repeat (4) tick();

    $display("[TB] write then read same address");
    c = cyc;
    applyStimulus(1, 15'h0100, 1, 1, 15'h0100, 8'hAA, 0, 0, 15'h0, 8'h0);
    q_vid.push_back('{c + 3, 8'h11});
    q_cack.push_back(c + 2);
    tick();
    applyStimulus(0, 15'h0, 1, 1, 15'h0100, 8'hAA, 0, 0, 15'h0, 8'h0);
    checkOutput("vid read before write ram_we", {31'h0, ram_we}, 0);
    tick(); idle();
    checkOutput("cpu write ram_we", {31'h0, ram_we}, 1);
    checkOutput("cpu write ram_din", {24'h0, ram_din}, 32'hAA);
    checkOutput("cpu write ram_addr", {17'h0, ram_addr}, 32'h0100);
    tick();
    checkOutput("idle ram_we", {31'h0, ram_we}, 0);
    checkOutput("idle ram_addr hold", {17'h0, ram_addr}, 32'h0100);
    c = cyc;
    applyStimulus(0, 15'h0, 1, 0, 15'h0100, 8'h0, 0, 0, 15'h0, 8'h0);
    q_cack.push_back(c + 1);
    q_cpu.push_back('{c + 3, 8'hAA});
    tick(); idle();
    tick();
    c = cyc;
    applyStimulus(0, 15'h0, 0, 0, 15'h0, 8'h0, 1, 0, 15'h0000, 8'h0);
    q_lack.push_back(c + 1);
    q_ldr.push_back('{c + 3, 8'h5A});
    tick(); idle();
    repeat (4) tick();

    $display("[TB] loader starvation relief");
    c = cyc;
    applyStimulus(0, 15'h0, 1, 1, 15'h0200, 8'h33, 1, 1, 15'h0300, 8'h44);
    for (int g = 0; g < 15; g++) q_cack.push_back(c + g + 1);
    q_lack.push_back(c + 16);
    q_cack.push_back(c + 17);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 16) begin
        ldr_req = 1'b0;
        checkOutput("starved ldr ram_addr", {17'h0, ram_addr}, 32'h0300);
        checkOutput("starved ldr ram_din", {24'h0, ram_din}, 32'h44);
      end
    end
    tick(); idle();
    checkOutput("cpu resumes ram_addr", {17'h0, ram_addr}, 32'h0200);
    repeat (4) tick();

    $display("[TB] reset with read in flight");
    c = cyc;
    applyStimulus(0, 15'h0, 1, 0, 15'h0000, 8'h0, 0, 0, 15'h0, 8'h0);
    q_cack.push_back(c + 1);
    tick(); idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("post-reset ram_addr", {17'h0, ram_addr}, 0);
    checkOutput("post-reset ram_din", {24'h0, ram_din}, 0);
    checkOutput("post-reset ram_we", {31'h0, ram_we}, 0);
    checkOutput("post-reset vid_dout", {24'h0, vid_dout}, 0);
    checkOutput("post-reset cpu_dout", {24'h0, cpu_dout}, 0);
    checkOutput("post-reset ldr_dout", {24'h0, ldr_dout}, 0);
    checkOutput("post-reset cpu_ack", {31'h0, cpu_ack}, 0);
    checkOutput("post-reset starve_cnt", {28'h0, dut.starve_cnt}, 0);
    repeat (6) tick();

`ifdef VRAM_ARB_STATS_EN
    $display("[TB] stall statistics");
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    tick();
    checkOutput("stat_cpu_stall after clr", {16'h0, stat_cpu_stall}, 0);
    c = cyc;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 15'h1800, 1, 1, 15'h0400, 8'h77, 0, 0, 15'h0, 8'h0);
      q_vid.push_back('{c + i + 3, 8'h47});
      tick();
    end
    applyStimulus(0, 15'h0, 1, 1, 15'h0400, 8'h77, 0, 0, 15'h0, 8'h0);
    q_cack.push_back(c + 11);
    tick(); idle();
    checkOutput("stat_cpu_stall", {16'h0, stat_cpu_stall}, 10);
    checkOutput("stat_ldr_stall", {16'h0, stat_ldr_stall}, 0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checkOutput("stat_cpu_stall cleared", {16'h0, stat_cpu_stall}, 0);
    repeat (4) tick();
`endif

    repeat (8) tick();
    checkOutput("vid queue drained", q_vid.size(), 0);
    checkOutput("cpu queue drained", q_cpu.size(), 0);
    checkOutput("ldr queue drained", q_ldr.size(), 0);
    checkOutput("cpu_ack queue drained", q_cack.size(), 0);
    checkOutput("ldr_ack queue drained", q_lack.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
